byte_unstriping: RTL and testbench

//  Receive-side counterpart of the two-lane byte striper: merges bytes arriving on lane 0 / lane 1 back

---
 rtl/byte_unstriping_if.sv | 28 ++
 rtl/byte_unstriping.sv | 129 ++++++++++++
 tb/tb_byte_unstriping.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_unstriping_if.sv
// Two-lane receive bus into the unstriper plus its merged single-stream output.
// Pure wiring: no latency of its own.
// Backpressure is carried by in_ready (toward lanes) and out_ready (from consumer).
interface byte_unstriping_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] lane0_data;
    logic              lane0_valid;
    logic [DATA_W-1:0] lane1_data;
    logic              lane1_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              out_ready;
    logic              skew_err;

    // Producer/consumer side: drives lane bytes and out_ready, observes the merged stream.
    modport master (
        output lane0_data, lane0_valid, lane1_data, lane1_valid, out_ready,
        input  in_ready, data_out, valid_out, skew_err
    );

    // Unstriper side.
    modport slave (
        input  lane0_data, lane0_valid, lane1_data, lane1_valid, out_ready,
        output in_ready, data_out, valid_out, skew_err
    );
endinterface

// File: rtl/byte_unstriping.sv
// Merges lane0 (even) / lane1 (odd) bytes into one ordered stream via per-lane FIFOs.
// Latency: a byte written at edge k is on data_out after edge k+1 at the earliest.
// Backpressure: in_ready drops when either lane FIFO is full; output holds while !out_ready.
module byte_unstriping #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    byte_unstriping_if.slave     bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] LANE0 = 1'b0;
    localparam logic [0:0] LANE1 = 1'b1;

    // Lane storage and pointers
    logic [DATA_W-1:0] fifo0_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo1_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr0_q, wr0_d, rd0_q, rd0_d;
    logic [PTR_W-1:0]  wr1_q, wr1_d, rd1_q, rd1_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Output stage and lane-select state
    logic [0:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              skew_q, skew_d;

    logic in_rdy;
    logic push0, push1;
    logic load, pop0, pop1;

    // Acceptance uses registered counts only; a same-cycle pop gives no credit.
    assign in_rdy = !reset && (cnt0_q < DEPTH_C) && (cnt1_q < DEPTH_C);
    assign push0  = bus.lane0_valid && in_rdy;
    assign push1  = bus.lane1_valid && in_rdy;

    // Output register may take a new byte when empty or when the consumer is taking the current one.
    assign load = !valid_q || bus.out_ready;
    assign pop0 = load && (sel_q == LANE0) && (cnt0_q != '0);
    assign pop1 = load && (sel_q == LANE1) && (cnt1_q != '0);

    assign bus.in_ready  = in_rdy;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.skew_err  = skew_q;

    // Pointer and occupancy next-state for both lanes; pointers wrap naturally at power-of-2 depth.
    always_comb begin
        wr0_d  = push0 ? wr0_q + PTR_W'(1) : wr0_q;
        wr1_d  = push1 ? wr1_q + PTR_W'(1) : wr1_q;
        rd0_d  = pop0  ? rd0_q + PTR_W'(1) : rd0_q;
        rd1_d  = pop1  ? rd1_q + PTR_W'(1) : rd1_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0 && !pop0) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end else if (!push0 && pop0) begin
            cnt0_d = cnt0_q - CNT_W'(1);
        end
        if (push1 && !pop1) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end else if (!push1 && pop1) begin
            cnt1_d = cnt1_q - CNT_W'(1);
        end
    end

    // Output stage: pop strictly from the selected lane; an empty selected lane stalls rather than skipping.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        skew_d  = skew_q;
        if (pop0) begin
            data_d = fifo0_q[rd0_q];
        end else if (pop1) begin
            data_d = fifo1_q[rd1_q];
        end
        if (load) begin
            valid_d = pop0 || pop1;
        end
        if (pop0 || pop1) begin
            sel_d = ~sel_q;
        end
        if (bus.lane1_valid && !bus.lane0_valid && in_rdy) begin
            skew_d = 1'b1;
        end
    end

    // Lane storage writes; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push0) begin
            fifo0_q[wr0_q] <= bus.lane0_data;
        end
        if (push1) begin
            fifo1_q[wr1_q] <= bus.lane1_data;
        end
    end

    // Control and output registers with synchronous reset that flushes everything buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr0_q   <= '0;
            rd0_q   <= '0;
            cnt0_q  <= '0;
            wr1_q   <= '0;
            rd1_q   <= '0;
            cnt1_q  <= '0;
            sel_q   <= LANE0;
            data_q  <= '0;
            valid_q <= 1'b0;
            skew_q  <= 1'b0;
        end else begin
            wr0_q   <= wr0_d;
            rd0_q   <= rd0_d;
            cnt0_q  <= cnt0_d;
            wr1_q   <= wr1_d;
            rd1_q   <= rd1_d;
            cnt1_q  <= cnt1_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            skew_q  <= skew_d;
        end
    end
endmodule

// File: tb/tb_byte_unstriping.sv
// Directed and randomized checks of the two-lane byte unstriper.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Random phase compares against a queue-based per-lane reference model.
module tb_byte_unstriping;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    byte_unstriping_if #(.DATA_W(8)) bus ();

    byte_unstriping #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        bus.lane0_valid = v0;
        bus.lane0_data  = d0;
        bus.lane1_valid = v1;
        bus.lane1_data  = d1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        cyc;
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.valid_out); end
        n_checks++;
        if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", bus.data_out); end
        n_checks++;
        if (bus.skew_err !== 1'b0) begin n_fail++; $display("FAIL reset_skew got %b exp 0", bus.skew_err); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_hi got %b exp 0", bus.in_ready); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_lo got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_seq [6];
        exp_seq = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c < 3) drive(1'b1, exp_seq[2*c], 1'b1, exp_seq[2*c+1]);
            else       drive(1'b0, 8'h00, 1'b0, 8'h00);
            cyc;
            if (c == 0) begin
                n_checks++;
                if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_no_bypass got %b exp 0", bus.valid_out); end
            end else begin
                n_checks++;
                if (bus.valid_out !== 1'b1 || bus.data_out !== exp_seq[c-1]) begin
                    n_fail++;
                    $display("FAIL b2b_data c=%0d got v=%b d=%h exp v=1 d=%h", c, bus.valid_out, bus.data_out, exp_seq[c-1]);
                end
            end
        end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", bus.valid_out); end
        n_checks++;
        if (bus.skew_err !== 1'b0) begin n_fail++; $display("FAIL b2b_skew got %b exp 0", bus.skew_err); end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_open i=%0d got %b exp 1", i, bus.in_ready); end
            drive(1'b1, 8'(8'h20 + 2*i), 1'b1, 8'(8'h21 + 2*i));
            cyc;
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b exp 0", bus.in_ready); end
        // Offered while full: must be dropped.
        drive(1'b1, 8'hEE, 1'b1, 8'hEF);
        cyc;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_still got %b exp 0", bus.in_ready); end
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h20) begin
            n_fail++; $display("FAIL bp_held got v=%b d=%h exp v=1 d=20", bus.valid_out, bus.data_out);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        bus.out_ready = 1'b1;
        for (int j = 1; j < 8; j++) begin
            cyc;
            n_checks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== 8'(8'h20 + j)) begin
                n_fail++; $display("FAIL bp_drain j=%0d got v=%b d=%h exp v=1 d=%h", j, bus.valid_out, bus.data_out, 8'(8'h20 + j));
            end
        end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0 (d=%h)", bus.valid_out, bus.data_out); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_odd_tail;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h10, 1'b1, 8'h11);
        cyc;
        drive(1'b1, 8'h12, 1'b0, 8'h00);
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h10) begin n_fail++; $display("FAIL odd_10 got v=%b d=%h exp v=1 d=10", bus.valid_out, bus.data_out); end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h11) begin n_fail++; $display("FAIL odd_11 got v=%b d=%h exp v=1 d=11", bus.valid_out, bus.data_out); end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h12) begin n_fail++; $display("FAIL odd_12 got v=%b d=%h exp v=1 d=12", bus.valid_out, bus.data_out); end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL odd_wait_lane1 got %b exp 0", bus.valid_out); end
        drive(1'b1, 8'h20, 1'b1, 8'h21);
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL odd_no_bypass got %b exp 0", bus.valid_out); end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h21) begin n_fail++; $display("FAIL odd_21 got v=%b d=%h exp v=1 d=21", bus.valid_out, bus.data_out); end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h20) begin n_fail++; $display("FAIL odd_20 got v=%b d=%h exp v=1 d=20", bus.valid_out, bus.data_out); end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL odd_drain got %b exp 0", bus.valid_out); end
        n_checks++;
        if (bus.skew_err !== 1'b0) begin n_fail++; $display("FAIL odd_skew got %b exp 0", bus.skew_err); end
    endtask

    // Lane select is LANE1 here (odd tail left lane0 one pop ahead), so the lone lane1 byte drains.
    task automatic test_skew;
        bus.out_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h55);
        cyc;
        n_checks++;
        if (bus.skew_err !== 1'b1) begin n_fail++; $display("FAIL skew_set got %b exp 1", bus.skew_err); end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h55) begin n_fail++; $display("FAIL skew_byte got v=%b d=%h exp v=1 d=55", bus.valid_out, bus.data_out); end
        cyc;
        cyc;
        n_checks++;
        if (bus.skew_err !== 1'b1) begin n_fail++; $display("FAIL skew_sticky got %b exp 1", bus.skew_err); end
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h30, 1'b1, 8'h31);
        cyc;
        drive(1'b1, 8'h32, 1'b1, 8'h33);
        cyc;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h30) begin n_fail++; $display("FAIL rmid_pre got v=%b d=%h exp v=1 d=30", bus.valid_out, bus.data_out); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready_rst got %b exp 0", bus.in_ready); end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 || bus.skew_err !== 1'b0) begin
            n_fail++; $display("FAIL rmid_cleared got v=%b d=%h s=%b exp v=0 d=00 s=0", bus.valid_out, bus.data_out, bus.skew_err);
        end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready_after got %b exp 1", bus.in_ready); end
        drive(1'b1, 8'hAA, 1'b1, 8'hBB);
        cyc;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hAA) begin n_fail++; $display("FAIL rmid_AA got v=%b d=%h exp v=1 d=AA", bus.valid_out, bus.data_out); end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hBB) begin n_fail++; $display("FAIL rmid_BB got v=%b d=%h exp v=1 d=BB", bus.valid_out, bus.data_out); end
        cyc;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_no_stale got v=%b d=%h exp v=0", bus.valid_out, bus.data_out); end
    endtask

    task automatic test_random;
        logic [7:0] q0 [$];
        logic [7:0] q1 [$];
        logic       m_sel, m_vld, m_skew, exp_ir, v0, v1, ordy, rst_now, ld;
        logic [7:0] m_dat, d0, d1;
        int         r;
        m_sel = 1'b0; m_vld = 1'b0; m_skew = 1'b0; m_dat = 8'h00;
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        cyc;
        reset = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            r    = $urandom_range(0, 19);
            v0   = (r < 15) || (r == 15);
            v1   = (r < 15) || (r == 16);
            if (r >= 17) begin v0 = 1'b0; v1 = 1'b0; end
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            rst_now = (i % 500 == 499);
            reset = rst_now;
            drive(v0, d0, v1, d1);
            bus.out_ready = ordy;
            #1;
            exp_ir = !rst_now && (q0.size() < 4) && (q1.size() < 4);
            n_checks++;
            if (bus.in_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_in_ready i=%0d got %b exp %b", i, bus.in_ready, exp_ir); end
            cyc;
            if (rst_now) begin
                q0.delete(); q1.delete();
                m_sel = 1'b0; m_vld = 1'b0; m_skew = 1'b0; m_dat = 8'h00;
            end else begin
                ld = !m_vld || ordy;
                if (ld) begin
                    if (!m_sel && q0.size() > 0) begin
                        m_dat = q0.pop_front(); m_vld = 1'b1; m_sel = 1'b1;
                    end else if (m_sel && q1.size() > 0) begin
                        m_dat = q1.pop_front(); m_vld = 1'b1; m_sel = 1'b0;
                    end else begin
                        m_vld = 1'b0;
                    end
                end
                if (exp_ir && v0) q0.push_back(d0);
                if (exp_ir && v1) q1.push_back(d1);
                if (exp_ir && v1 && !v0) m_skew = 1'b1;
            end
            n_checks++;
            if (bus.valid_out !== m_vld) begin n_fail++; $display("FAIL rnd_valid i=%0d got %b exp %b", i, bus.valid_out, m_vld); end
            if (m_vld) begin
                n_checks++;
                if (bus.data_out !== m_dat) begin n_fail++; $display("FAIL rnd_data i=%0d got %h exp %h", i, bus.data_out, m_dat); end
            end
            n_checks++;
            if (bus.skew_err !== m_skew) begin n_fail++; $display("FAIL rnd_skew i=%0d got %b exp %b", i, bus.skew_err, m_skew); end
        end
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_odd_tail;
        test_skew;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
